// File: rtl/fix_checksum_gen_pkg.sv
// Shared types and constants for the FIX trailer checksum generator.
// Also provides the single double-dabble step used by the BCD converter.
package fix_pkg;

  localparam int DATA_W      = 8;
  localparam int CONV_CYCLES = 8;

  localparam logic [7:0] SOH  = 8'h01;
  localparam logic [7:0] EQ   = 8'h3d;
  localparam logic [7:0] ZERO = 8'h30;

  typedef enum logic [1:0] {IDLE, ACCUM, CONV, READY} state_t;

  // {hund, tens, ones, bin}: correct tens/ones nibbles >= 5, then shift left.
  // Hundreds never exceeds 2 for an 8-bit input, so it needs no correction.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/fix_checksum_gen_if.sv
// Byte-tap and digit-delivery bus between the message-create FSM and the checksum generator.
// body_len_o exists only when FIX_CHKSUM_BODYLEN_EN is defined.
interface fix_checksum_gen_if;
  import fix_pkg::*;

  // Handshake: a digit transfers on any cycle where digit_valid_o & digit_rd_i;
  // digit_o is held stable until that happens. Bytes are qualified by byte_valid_i only.
  logic [DATA_W-1:0] byte_i;
  logic              byte_valid_i;
  logic              sof_i;
  logic              eof_i;
  logic              digit_rd_i;
  logic [7:0]        digit_o;
  logic              digit_valid_o;
  logic [DATA_W-1:0] sum_o;
  logic              busy_o;
  logic              done_o;
  logic              drop_o;
  state_t            dbg_state;
`ifdef FIX_CHKSUM_BODYLEN_EN
  logic [15:0]       body_len_o;
`endif

  modport master (
    output byte_i, byte_valid_i, sof_i, eof_i, digit_rd_i,
`ifdef FIX_CHKSUM_BODYLEN_EN
    input  body_len_o,
`endif
    input  digit_o, digit_valid_o, sum_o, busy_o, done_o, drop_o, dbg_state
  );

  modport slave (
    input  byte_i, byte_valid_i, sof_i, eof_i, digit_rd_i,
`ifdef FIX_CHKSUM_BODYLEN_EN
    output body_len_o,
`endif
    output digit_o, digit_valid_o, sum_o, busy_o, done_o, drop_o, dbg_state
  );

endinterface

// File: rtl/fix_checksum_gen_bcd.sv
// Sequential 8-bit binary-to-BCD (double dabble). The first step is folded into the
// load, so results and the done pulse appear CYCLES-1 cycles after start.
module bin2bcd8_seq
  import fix_pkg::*;
#(
  parameter int CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [19:0] r_shift;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic        r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_shift <= dabble_step({12'd0, bin});
        r_cnt   <= 4'(CYCLES - 1);
        r_run   <= 1'b1;
      end else if (r_run) begin
        r_shift <= dabble_step(r_shift);
        r_cnt   <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign hund = r_shift[19:16];
  assign tens = r_shift[15:12];
  assign ones = r_shift[11:8];

endmodule

// File: rtl/fix_checksum_gen.sv
// FIX tag-10 checksum: sums tapped bytes mod 256, converts to BCD, serves three ASCII digits.
// Optional FIX_CHKSUM_BODYLEN_EN adds body_len_o, the count of summed bytes.
module fix_checksum_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int CONV_CYCLES = 8
) (
  input logic              clk,
  input logic              rst,
  fix_checksum_gen_if.slave bus
);
  import fix_pkg::*;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] r_sum_o;
  logic [7:0]            r_digit;
  logic                  r_digit_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_drop;
  logic [1:0]            r_idx;

  logic                  w_start;
  logic [7:0]            w_bin;
  logic                  w_conv_done;
  logic [3:0]            w_hund, w_tens, w_ones;

  // An sof together with eof is an empty message: convert zero.
  assign w_start = bus.byte_valid_i && bus.eof_i &&
                   ((r_state == IDLE && bus.sof_i) || r_state == ACCUM);
  assign w_bin   = bus.sof_i ? 8'd0 : r_sum;

  bin2bcd8_seq #(.CYCLES(CONV_CYCLES)) u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .bin  (w_bin),
    .done (w_conv_done),
    .hund (w_hund),
    .tens (w_tens),
    .ones (w_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sum         <= '0;
      r_sum_o       <= '0;
      r_digit       <= ZERO;
      r_digit_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_drop        <= 1'b0;
      r_idx         <= 2'd0;
    end else begin
      r_done <= 1'b0;
      r_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.byte_valid_i && bus.sof_i) begin
            r_busy <= 1'b1;
            if (bus.eof_i) begin
              r_sum   <= '0;
              r_sum_o <= '0;
              r_state <= CONV;
            end else begin
              r_sum   <= bus.byte_i;
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.byte_valid_i) begin
            if (bus.eof_i) begin
              r_sum_o <= bus.sof_i ? '0 : r_sum;
              if (bus.sof_i) r_sum <= '0;
              r_state <= CONV;
            end else if (bus.sof_i) begin
              r_sum <= bus.byte_i;
            end else begin
              r_sum <= r_sum + bus.byte_i;
            end
          end
        end
        CONV: begin
          if (bus.byte_valid_i) r_drop <= 1'b1;
          if (w_conv_done) begin
            r_state       <= READY;
            r_busy        <= 1'b0;
            r_digit_valid <= 1'b1;
            r_digit       <= ZERO + {4'd0, w_hund};
            r_idx         <= 2'd0;
          end
        end
        READY: begin
          if (bus.byte_valid_i) r_drop <= 1'b1;
          if (bus.digit_rd_i) begin
            case (r_idx)
              2'd0: begin
                r_idx   <= 2'd1;
                r_digit <= ZERO + {4'd0, w_tens};
              end
              2'd1: begin
                r_idx   <= 2'd2;
                r_digit <= ZERO + {4'd0, w_ones};
              end
              default: begin
                r_idx         <= 2'd0;
                r_digit       <= ZERO;
                r_digit_valid <= 1'b0;
                r_done        <= 1'b1;
                r_state       <= IDLE;
              end
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FIX_CHKSUM_BODYLEN_EN
  logic [15:0] r_body_len;

  // Counts only bytes that enter the sum; frozen at eof, zero for empty messages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_body_len <= '0;
    end else if (bus.byte_valid_i &&
                 ((r_state == IDLE && bus.sof_i) || r_state == ACCUM)) begin
      if (bus.sof_i)
        r_body_len <= bus.eof_i ? 16'd0 : 16'd1;
      else if (!bus.eof_i && r_body_len != 16'hFFFF)
        r_body_len <= r_body_len + 16'd1;
    end
  end

  assign bus.body_len_o = r_body_len;
`endif

  assign bus.digit_o       = r_digit;
  assign bus.digit_valid_o = r_digit_valid;
  assign bus.sum_o         = r_sum_o;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.drop_o        = r_drop;
  assign bus.dbg_state     = r_state;

endmodule
